// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the IF/ID register.
// Optional macro FETCH_MISALIGN_CHECK_EN: raise a misaligned-fetch fault when pc_q[1:0] != 0.
module fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] pc_addr,
  input  logic [31:0] imem_instr,
  input  logic        imem_exc_en,
  input  logic [3:0]  imem_exc_code,
  input  logic [63:0] imem_exc_val,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_exc_en,
  output logic [3:0]  if_exc_code,
  output logic [63:0] if_exc_val
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [63:0] if_pc_q, if_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        exc_en_q, exc_en_d;
  logic [3:0]  exc_code_q, exc_code_d;
  logic [63:0] exc_val_q, exc_val_d;

  logic advance;
  logic misaligned;

  assign advance = !valid_q || id_ready;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-value starts as a hold of its register so no path infers a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    if_pc_d    = if_pc_q;
    instr_d    = instr_q;
    exc_en_d   = exc_en_q;
    exc_code_d = exc_code_q;
    exc_val_d  = exc_val_q;

    if (redirect_en) begin
      // Flush wins over any pending handshake so the stale entry never reaches decode.
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      state_d = RUN;
    end else begin
      unique case (state_q)
        RUN: begin
          if (advance) begin
            valid_d = 1'b1;
            if_pc_d = pc_q;
            if (misaligned) begin
              instr_d    = NOP_INSTR;
              exc_en_d   = 1'b1;
              exc_code_d = 4'd0;
              exc_val_d  = pc_q;
              state_d    = HALT;
            end else if (imem_exc_en) begin
              instr_d    = NOP_INSTR;
              exc_en_d   = 1'b1;
              exc_code_d = imem_exc_code;
              exc_val_d  = imem_exc_val;
              state_d    = HALT;
            end else begin
              instr_d  = imem_instr;
              exc_en_d = 1'b0;
              pc_d     = pc_q + 64'd4;
            end
          end
        end
        HALT: begin
          // Fault entry drains once; nothing new loads until a redirect.
          if (valid_q && id_ready) valid_d = 1'b0;
        end
        default: state_d = RUN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      if_pc_q    <= 64'h0;
      instr_q    <= NOP_INSTR;
      exc_en_q   <= 1'b0;
      exc_code_q <= 4'd0;
      exc_val_q  <= 64'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      if_pc_q    <= if_pc_d;
      instr_q    <= instr_d;
      exc_en_q   <= exc_en_d;
      exc_code_q <= exc_code_d;
      exc_val_q  <= exc_val_d;
    end
  end

  assign pc_addr     = pc_q;
  assign if_valid    = valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = instr_q;
  assign if_exc_en   = exc_en_q;
  assign if_exc_code = exc_code_q;
  assign if_exc_val  = exc_val_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard queue of expected IF/ID entries plus direct PC/valid checks.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pc_addr;
  logic [31:0] imem_instr;
  logic        imem_exc_en;
  logic [3:0]  imem_exc_code;
  logic [63:0] imem_exc_val;
  logic        redirect_en;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        if_exc_en;
  logic [3:0]  if_exc_code;
  logic [63:0] if_exc_val;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        exc_en;
    logic [3:0]  code;
    logic [63:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0050_0093;
    return a[31:0] ^ 32'h1234_5678;
  endfunction

  assign imem_instr = mem_word(pc_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .imem_instr(imem_instr),
    .imem_exc_en(imem_exc_en), .imem_exc_code(imem_exc_code), .imem_exc_val(imem_exc_val),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_exc_en(if_exc_en),
    .if_exc_code(if_exc_code), .if_exc_val(if_exc_val)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_ok(input logic [63:0] pc);
    exp_q.push_back('{pc: pc, instr: mem_word(pc), exc_en: 1'b0, code: 4'd0, val: 64'h0});
  endtask

  task automatic push_fault(input logic [63:0] pc, input logic [3:0] code, input logic [63:0] val);
    exp_q.push_back('{pc: pc, instr: NOP, exc_en: 1'b1, code: code, val: val});
  endtask

  // Advance one clock, sample 1 time unit after the edge, retire any expected entry.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_valid", 64'(if_valid), 64'd1);
      chk("sb_pc", if_pc, e.pc);
      chk("sb_instr", 64'(if_instr), 64'(e.instr));
      chk("sb_exc_en", 64'(if_exc_en), 64'(e.exc_en));
      if (e.exc_en) begin
        chk("sb_exc_code", 64'(if_exc_code), 64'(e.code));
        chk("sb_exc_val", if_exc_val, e.val);
      end
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, 64'(if_valid), 64'd0);
    chk({tag, "_pc_addr"}, pc_addr, 64'h0);
    chk({tag, "_if_pc"}, if_pc, 64'h0);
    chk({tag, "_instr"}, 64'(if_instr), 64'(NOP));
    chk({tag, "_exc_en"}, 64'(if_exc_en), 64'd0);
    chk({tag, "_exc_code"}, 64'(if_exc_code), 64'd0);
    chk({tag, "_exc_val"}, if_exc_val, 64'h0);
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_en = 1'b1;
    redirect_pc = pc;
    tick();
    redirect_en = 1'b0;
    chk("redir_flush", 64'(if_valid), 64'd0);
    chk("redir_pc_addr", pc_addr, pc);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; id_ready = 1'b1; redirect_en = 1'b0; redirect_pc = 64'h0;
    imem_exc_en = 1'b0; imem_exc_code = 4'd0; imem_exc_val = 64'h0;
    #2;
    check_reset_values("rst");
    #10 rst = 1'b0;

    // 1: first fetch after reset
    push_ok(64'h0);
    tick();
    chk("t1_pc_addr", pc_addr, 64'h4);

    // 2: stall holds entry and PC
    push_ok(64'h4);
    tick();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_stall_pc", if_pc, 64'h4);
      chk("t2_stall_addr", pc_addr, 64'h8);
      chk("t2_stall_valid", 64'(if_valid), 64'd1);
    end
    id_ready = 1'b1;
    push_ok(64'h8);
    tick();
    chk("t2_pc_addr", pc_addr, 64'hC);

    // 3: redirect flushes even while decode is stalled
    id_ready = 1'b0;
    redirect(64'h100);
    push_ok(64'h100);
    tick();
    chk("t3_pc_addr", pc_addr, 64'h104);
    id_ready = 1'b1;

    // 4: fetch fault, halt until redirect; fault inputs ignored while halted
    redirect(64'h4_0000);
    imem_exc_en = 1'b1; imem_exc_code = 4'd1; imem_exc_val = 64'h4_0000;
    id_ready = 1'b0;
    push_fault(64'h4_0000, 4'd1, 64'h4_0000);
    tick();
    chk("t4_pc_hold", pc_addr, 64'h4_0000);
    imem_exc_code = 4'd5;
    tick();
    chk("t4_hold_valid", 64'(if_valid), 64'd1);
    chk("t4_hold_code", 64'(if_exc_code), 64'd1);
    imem_exc_en = 1'b0;
    id_ready = 1'b1;
    tick();
    chk("t4_consumed", 64'(if_valid), 64'd0);
    tick();
    chk("t4_halt_valid", 64'(if_valid), 64'd0);
    chk("t4_halt_pc", pc_addr, 64'h4_0000);
    redirect(64'h200);
    push_ok(64'h200);
    tick();
    chk("t4_resume_addr", pc_addr, 64'h204);

    // PC wrap at the top of the address space
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    push_ok(64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("wrap_pc_addr", pc_addr, 64'h0);

    // 5: asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    push_ok(64'h0);
    tick();
    chk("t5_pc_addr", pc_addr, 64'h4);

    // 6: misaligned redirect target
    redirect(64'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
    push_fault(64'h102, 4'd0, 64'h102);
    tick();
    chk("t6_pc_hold", pc_addr, 64'h102);
    tick();
    chk("t6_halt_valid", 64'(if_valid), 64'd0);
`else
    push_ok(64'h102);
    tick();
    chk("t6_pc_addr", pc_addr, 64'h106);
`endif

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
